// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-adder cell computes a + ~b + 1
// LSB first, with a start/busy/done handshake and registered, held results.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  // Full-adder cell; the subtrahend bit is inverted to form a + ~b + 1.
  logic             nb_bit;
  logic             sum_bit;
  logic             carry_out;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    nb_bit    = ~b_sr_q[0];
    sum_bit   = a_sr_q[0] ^ nb_bit ^ carry_q;
    carry_out = (a_sr_q[0] & nb_bit) | (carry_q & (a_sr_q[0] ^ nb_bit));
    res_next  = {sum_bit, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          res_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = res_next;
        carry_d = carry_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // On the MSB cell carry_q is the carry into the MSB.
          diff_d     = res_next;
          borrow_d   = ~carry_out;
          overflow_d = carry_q ^ carry_out;
          zero_d     = (res_next == '0);
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed and random 8-bit operations, handshake and
// reset checks, and an exhaustive 4-bit sweep against an arithmetic reference.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8, overflow8, zero8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, borrow4, overflow4, zero4;
  logic [3:0] diff4;

  int n_checks = 0;
  int n_errors = 0;

  // Expected result packing: {zero, overflow, borrow, diff[31:0]}
  logic [34:0] exp8_q[$];
  logic [34:0] exp4_q[$];
  logic [34:0] held8 = '0;
  logic [34:0] held4 = '0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8),
    .overflow(overflow8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4),
    .overflow(overflow4), .zero(zero4)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [34:0] ref_model(input int w, input logic [31:0] a, input logic [31:0] b);
    longint unsigned m, ua, ub, d;
    logic sa, sb, sd, bo, ov, z;
    m  = (64'd1 << w) - 64'd1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    d  = (ua + (m + 64'd1) - ub) & m;
    bo = (ua < ub);
    sa = ((ua >> (w - 1)) & 64'd1) != 0;
    sb = ((ub >> (w - 1)) & 64'd1) != 0;
    sd = ((d  >> (w - 1)) & 64'd1) != 0;
    ov = (sa != sb) && (sd != sa);
    z  = (d == 0);
    return {z, ov, bo, d[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res8(input string tag, input logic [34:0] e);
    chk({tag, "_diff"},     {24'd0, diff8},     e[31:0]);
    chk({tag, "_borrow"},   {31'd0, borrow8},   {31'd0, e[32]});
    chk({tag, "_overflow"}, {31'd0, overflow8}, {31'd0, e[33]});
    chk({tag, "_zero"},     {31'd0, zero8},     {31'd0, e[34]});
  endtask

  task automatic chk_res4(input string tag, input logic [34:0] e);
    chk({tag, "_diff"},     {28'd0, diff4},     e[31:0]);
    chk({tag, "_borrow"},   {31'd0, borrow4},   {31'd0, e[32]});
    chk({tag, "_overflow"}, {31'd0, overflow4}, {31'd0, e[33]});
    chk({tag, "_zero"},     {31'd0, zero4},     {31'd0, e[34]});
  endtask

  // Driver: called at a negedge while dut8 is idle; returns at the negedge of the
  // done cycle. inject_cyc >= 0 pulses a stray start with other operands mid-op.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int inject_cyc);
    logic [34:0] e;
    a8 = a; b8 = b; start8 = 1'b1;
    exp8_q.push_back(ref_model(8, {24'd0, a}, {24'd0, b}));
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      chk("busy8", {31'd0, busy8}, 32'd1);
      chk("no_done8", {31'd0, done8}, 32'd0);
      chk_res8("hold8", held8);
      start8 = (i == inject_cyc);
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("done8", {31'd0, done8}, 32'd1);
    chk("busy_low8", {31'd0, busy8}, 32'd0);
    if (exp8_q.size() == 0) begin
      chk("exp8_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp8_q.pop_front();
      chk_res8("res8", e);
      held8 = e;
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    logic [34:0] e;
    a4 = a; b4 = b; start4 = 1'b1;
    exp4_q.push_back(ref_model(4, {28'd0, a}, {28'd0, b}));
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busy4", {31'd0, busy4}, 32'd1);
      @(negedge clk);
    end
    chk("done4", {31'd0, done4}, 32'd1);
    if (exp4_q.size() == 0) begin
      chk("exp4_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp4_q.pop_front();
      chk_res4("res4", e);
      held4 = e;
    end
  endtask

  task automatic idle8();
    @(negedge clk);
    chk("idle_done8", {31'd0, done8}, 32'd0);
    chk("idle_busy8", {31'd0, busy8}, 32'd0);
    chk_res8("idle_hold8", held8);
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk_res8("rst8", 35'd0);
    chk("rst_busy4", {31'd0, busy4}, 32'd0);
    chk_res4("rst4", 35'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed operand patterns
    op8(8'h05, 8'h03, -1);
    idle8();
    op8(8'h03, 8'h05, -1);
    idle8();
    op8(8'h80, 8'h01, -1);
    idle8();
    op8(8'h7F, 8'hFF, -1);
    idle8();
    op8(8'h2A, 8'h2A, -1);
    idle8();
    op8(8'hC3, 8'h00, -1);
    idle8();

    // stray start 3 cycles into an operation is ignored
    op8(8'h05, 8'h03, 3);
    idle8();

    // start in the done cycle: back-to-back, next done exactly 8 busy cycles later
    op8(8'h10, 8'h20, -1);
    op8(8'hFF, 8'h01, -1);
    op8(8'h00, 8'h80, -1);
    idle8();

    // random operands
    for (int n = 0; n < 20; n++) begin
      op8(8'($urandom), 8'($urandom_range(0, 255)), -1);
      if ($urandom_range(0, 1) == 1) idle8();
    end

    // reset mid-operation aborts without a done pulse
    a8 = 8'h44; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy8", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy8", {31'd0, busy8}, 32'd0);
    chk("abort_done8", {31'd0, done8}, 32'd0);
    chk_res8("abort8", 35'd0);
    held8 = '0;
    held4 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_abort_done8", {31'd0, done8}, 32'd0);
      chk("post_abort_busy8", {31'd0, busy8}, 32'd0);
    end
    chk_res8("post_abort_hold8", held8);
    op8(8'h44, 8'h11, -1);

    // exhaustive 4-bit sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        op4(4'(ia), 4'(ib));
      end
    end
    @(negedge clk);
    chk("final_done4", {31'd0, done4}, 32'd0);
    chk_res4("final_hold4", held4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes diff = a - b one bit per clock, LSB first.
- Datapath is a single full-adder cell fed with ~b and an initial carry-in of 1, plus a carry/borrow flip-flop.
- Intended for area-constrained arithmetic paths, where one adder cell replaces a WIDTH-bit ripple subtractor.
- Start/busy/done handshake; results are registered and held until the next completion.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2 to 32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when results update.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow  output  1  1 when unsigned a < b (inverse of the final carry-out).
- overflow  output  1  signed overflow of a - b.
- zero  output  1  1 when diff == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy, done, diff, borrow, overflow, zero all 0.
  - Internal shift registers, bit counter and carry flip-flop cleared.
- States: IDLE, SHIFT.
- IDLE, start = 1 at an edge:
  - Load a and b into shift registers.
  - carry = 1, counter = 0.
  - Go to SHIFT; busy = 1 from the next cycle.
- SHIFT, each edge:
  - s = a_sr[0] ^ ~b_sr[0] ^ carry.
  - carry <= (a_sr[0] & ~b_sr[0]) | (carry & (a_sr[0] ^ ~b_sr[0])).
  - s is shifted into the MSB of the result shift register; a_sr and b_sr shift right.
  - counter increments.
  - On the edge processing bit WIDTH-1, the carry into the MSB cell is retained for the overflow computation.
- Completion edge (the edge processing bit WIDTH-1):
  - diff = assembled result.
  - borrow = ~carry_out.
  - overflow = carry_into_msb ^ carry_out.
  - zero = (result == 0).
  - done = 1 for exactly one cycle; busy = 0; state returns to IDLE.
- Latency:
  - Accepting edge = edge 0.
  - busy is high for exactly WIDTH cycles.
  - done is high in the cycle following edge WIDTH.
  - Results are valid in that same cycle.
- start while busy is ignored; a and b may change freely during SHIFT without effect.
- start asserted during the done cycle is accepted (state is IDLE), giving back-to-back operation with no idle gap.
- diff, borrow, overflow and zero hold their values until the next completion edge; they do not change during SHIFT.
- Reset mid-operation aborts immediately: no done pulse, and outputs return to 0.
- Operand edge values:
  - a = b gives zero = 1, borrow = 0.
  - b = 0 gives diff = a, borrow = 0, overflow = 0.

Test Plan:
- WIDTH=8; a=5, b=3, start for 1 cycle:
  - busy high for 8 cycles, done on the 9th cycle after the accepting edge.
  - diff=0x02, borrow=0, overflow=0, zero=0.
- a=3, b=5:
  - diff=0xFE, borrow=1, overflow=0, zero=0.
- a=0x80, b=0x01:
  - diff=0x7F, borrow=0, overflow=1.
- a=0x7F, b=0xFF:
  - diff=0x80, borrow=1, overflow=1.
- a=0x2A, b=0x2A:
  - diff=0x00, zero=1, borrow=0.
- Handshake and reset:
  - Pulse start again 3 cycles into an operation with different operands: ignored, and the first result is unchanged.
  - Assert start in the done cycle: the second result completes exactly 8 cycles later.
  - Drop rst_n mid-SHIFT: all outputs 0 at once, and no done pulse follows.
- WIDTH=4, exhaustive 256 operand pairs:
  - diff, borrow, overflow and zero match a reference model for every pair.
